huff_stream_sched: RTL and testbench



---
 rtl/huff_stream_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_huff_stream_sched.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_stream_sched.sv
// Frame scheduler for the Huffman decoder: slices packed code words MSB-first into
// 1..4 bit chunks, counts decoded symbols and closes the frame on the programmed count.
// Optional statistics counters are built when HUFF_SCHED_STATS_EN is defined.
module huff_stream_sched #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned SYM_W   = 12,
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [SYM_W-1:0]  frame_syms,
  input  logic              w_valid,
  input  logic [WORD_W-1:0] w_data,
  input  logic              w_last,
  input  logic [5:0]        w_last_bits,
  output logic              w_ready,
  input  logic              aready,
  output logic              svalid,
  output logic [3:0]        in_data,
  output logic [2:0]        in_len,
  input  logic              tvalid,
  output logic              busy,
  output logic              done,
  output logic [SYM_W-1:0]  sym_count,
  output logic              err_underrun
`ifdef HUFF_SCHED_STATS_EN
  ,
  output logic [15:0]       bits_fed,
  output logic [7:0]        words_fed
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StFeed,
    StWait,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  hold_q, hold_d;
  logic [5:0]         bits_left_q, bits_left_d;
  logic               last_q, last_d;
  logic [SYM_W-1:0]   frame_syms_q, frame_syms_d;
  logic [SYM_W-1:0]   sym_count_q, sym_count_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [15:0]        to_cnt_q, to_cnt_d;
  logic               w_ready_q, w_ready_d;
  logic               svalid_q, svalid_d;
  logic [3:0]         in_data_q, in_data_d;
  logic [2:0]         in_len_q, in_len_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               active;
  logic               finish;
  logic [SYM_W-1:0]   sym_inc;
  logic [5:0]         last_bits;
  logic [2:0]         chunk_len;
  logic [3:0]         chunk_top;

`ifdef HUFF_SCHED_STATS_EN
  logic [15:0]        bits_fed_q, bits_fed_d;
  logic [7:0]         words_fed_q, words_fed_d;
  logic [16:0]        bits_sum;
`endif

  // Shared decode of the current word/chunk geometry.
  always_comb begin
    active    = (state_q == StFetch) || (state_q == StFeed) ||
                (state_q == StWait) || (state_q == StDrain);
    sym_inc   = sym_count_q + SYM_W'(1);
    finish    = active && tvalid && (sym_inc == frame_syms_q);
    // Out-of-range final bit counts fall back to a full word.
    last_bits = ((w_last_bits == 6'd0) || (32'(w_last_bits) > WORD_W)) ?
                6'(WORD_W) : w_last_bits;
    chunk_len = (bits_left_q >= 6'd4) ? 3'd4 : bits_left_q[2:0];
    chunk_top = hold_q[WORD_W-1 -: 4];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    bits_left_d  = bits_left_q;
    last_d       = last_q;
    frame_syms_d = frame_syms_q;
    sym_count_d  = sym_count_q;
    hold_cnt_d   = hold_cnt_q;
    to_cnt_d     = to_cnt_q;
    svalid_d     = 1'b0;
    in_data_d    = in_data_q;
    in_len_d     = in_len_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
`ifdef HUFF_SCHED_STATS_EN
    bits_fed_d   = bits_fed_q;
    words_fed_d  = words_fed_q;
    bits_sum     = {1'b0, bits_fed_q} + 17'(chunk_len);
`endif

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          frame_syms_d = frame_syms;
          sym_count_d  = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
`ifdef HUFF_SCHED_STATS_EN
          bits_fed_d   = '0;
          words_fed_d  = '0;
`endif
          state_d      = (frame_syms == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (w_valid && w_ready_q) begin
          hold_d      = w_data;
          bits_left_d = w_last ? last_bits : 6'(WORD_W);
          last_d      = w_last;
`ifdef HUFF_SCHED_STATS_EN
          if (words_fed_q != 8'hFF) words_fed_d = words_fed_q + 8'd1;
`endif
          state_d     = StFeed;
        end
      end
      StFeed: begin
        // A chunk is withheld when the frame is closing or being aborted this cycle.
        if (aready && !finish && !abort) begin
          svalid_d    = 1'b1;
          in_len_d    = chunk_len;
          in_data_d   = chunk_top >> (3'd4 - chunk_len);
          hold_d      = hold_q << chunk_len;
          bits_left_d = bits_left_q - {3'b000, chunk_len};
          hold_cnt_d  = '0;
`ifdef HUFF_SCHED_STATS_EN
          bits_fed_d  = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
`endif
          state_d     = StWait;
        end
      end
      StWait: begin
        if (32'(hold_cnt_q) + 32'd1 >= HOLDOFF) begin
          if (bits_left_q != 6'd0) begin
            state_d = StFeed;
          end else if (!last_q) begin
            state_d = StFetch;
          end else begin
            to_cnt_d = '0;
            state_d  = StDrain;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      StDrain: begin
        if (tvalid) begin
          to_cnt_d = '0;
        end else if (32'(to_cnt_q) + 32'd1 >= TIMEOUT) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Symbol counting overrides the bit-feeding transitions.
    if (active && tvalid) begin
      if (sym_count_q < frame_syms_q) sym_count_d = sym_inc;
      if (finish) state_d = StDone;
    end

    if (abort) begin
      state_d  = StIdle;
      svalid_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end

    w_ready_d = (state_d == StFetch);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      bits_left_q  <= '0;
      last_q       <= 1'b0;
      frame_syms_q <= '0;
      sym_count_q  <= '0;
      hold_cnt_q   <= '0;
      to_cnt_q     <= '0;
      w_ready_q    <= 1'b0;
      svalid_q     <= 1'b0;
      in_data_q    <= '0;
      in_len_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      bits_left_q  <= bits_left_d;
      last_q       <= last_d;
      frame_syms_q <= frame_syms_d;
      sym_count_q  <= sym_count_d;
      hold_cnt_q   <= hold_cnt_d;
      to_cnt_q     <= to_cnt_d;
      w_ready_q    <= w_ready_d;
      svalid_q     <= svalid_d;
      in_data_q    <= in_data_d;
      in_len_q     <= in_len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef HUFF_SCHED_STATS_EN
  // Statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_fed_q  <= '0;
      words_fed_q <= '0;
    end else begin
      bits_fed_q  <= bits_fed_d;
      words_fed_q <= words_fed_d;
    end
  end

  assign bits_fed  = bits_fed_q;
  assign words_fed = words_fed_q;
`endif

  assign w_ready      = w_ready_q;
  assign svalid       = svalid_q;
  assign in_data      = in_data_q;
  assign in_len       = in_len_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sym_count    = sym_count_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_huff_stream_sched.sv
// Directed bench for huff_stream_sched: chunking, symbol counting, underrun, abort, reset.
module tb_huff_stream_sched;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned SYM_W   = 12;
  localparam int unsigned HOLDOFF = 2;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort;
  logic [SYM_W-1:0]  frame_syms;
  logic              w_valid;
  logic [WORD_W-1:0] w_data;
  logic              w_last;
  logic [5:0]        w_last_bits;
  logic              w_ready;
  logic              aready;
  logic              svalid;
  logic [3:0]        in_data;
  logic [2:0]        in_len;
  logic              tvalid;
  logic              busy, done;
  logic [SYM_W-1:0]  sym_count;
  logic              err_underrun;
`ifdef HUFF_SCHED_STATS_EN
  logic [15:0]       bits_fed;
  logic [7:0]        words_fed;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [3:0] ch_data [8];
  logic [2:0] ch_len  [8];
  int         ch_cyc  [8];
  int         n_ch;

  huff_stream_sched #(
    .WORD_W (WORD_W),
    .SYM_W  (SYM_W),
    .HOLDOFF(HOLDOFF),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .frame_syms  (frame_syms),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .w_last      (w_last),
    .w_last_bits (w_last_bits),
    .w_ready     (w_ready),
    .aready      (aready),
    .svalid      (svalid),
    .in_data     (in_data),
    .in_len      (in_len),
    .tvalid      (tvalid),
    .busy        (busy),
    .done        (done),
    .sym_count   (sym_count),
    .err_underrun(err_underrun)
`ifdef HUFF_SCHED_STATS_EN
    ,
    .bits_fed    (bits_fed),
    .words_fed   (words_fed)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Pulse start for one rising edge; returns at the following falling edge.
  task automatic begin_frame(input logic [SYM_W-1:0] syms);
    frame_syms = syms;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one word and hold it until the handshake edge has passed.
  task automatic give_word(input logic [WORD_W-1:0] data, input logic last,
                           input logic [5:0] lbits, output logic ok);
    w_data = data;
    w_last = last;
    w_last_bits = lbits;
    w_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (w_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    w_valid = 1'b0;
    w_last = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    n_ch = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (svalid && n_ch < 8) begin
        ch_data[n_ch] = in_data;
        ch_len[n_ch]  = in_len;
        ch_cyc[n_ch]  = cyc;
        n_ch++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 0; abort = 0; frame_syms = '0; w_valid = 0; w_data = '0; w_last = 0;
    w_last_bits = '0; aready = 0; tvalid = 0;
    #1;
    vectors++;
    if ({w_ready, svalid, busy, done, err_underrun} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000", {w_ready, svalid, busy, done, err_underrun});
      miscompares++;
    end
    vectors++;
    if ({in_data, in_len} !== 7'b0) begin
      $display("FAIL reset_chunk: got %h want 0", {in_data, in_len});
      miscompares++;
    end
    vectors++;
    if (sym_count !== '0) begin
      $display("FAIL reset_sym_count: got %0d want 0", sym_count);
      miscompares++;
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (w_ready !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL idle_after_reset: got w_ready=%b busy=%b want 0 0", w_ready, busy);
      miscompares++;
    end
  endtask

  task automatic test_one_chunk();
    logic ok;
    int   seen;
    aready = 1'b1;
    begin_frame(12'd3);
    vectors++;
    if (busy !== 1'b1 || w_ready !== 1'b1) begin
      $display("FAIL one_start: got busy=%b w_ready=%b want 1 1", busy, w_ready);
      miscompares++;
    end
    give_word(16'h0000, 1'b1, 6'd3, ok);
    vectors++;
    if (ok !== 1'b1) begin
      $display("FAIL one_accept: got %b want 1", ok);
      miscompares++;
    end
    collect(4);
    vectors++;
    if (n_ch !== 1 || ch_len[0] !== 3'd3 || ch_data[0] !== 4'h0) begin
      $display("FAIL one_chunk: got n=%0d len=%0d data=%h want n=1 len=3 data=0",
               n_ch, ch_len[0], ch_data[0]);
      miscompares++;
    end
    tvalid = 1'b1;
    tick(); tick(); tick();
    tvalid = 1'b0;
    vectors++;
    if (sym_count !== 12'd3 || done !== 1'b0) begin
      $display("FAIL one_count: got sym=%0d done=%b want 3 0", sym_count, done);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL one_done: got done=%b busy=%b want 1 0", done, busy);
      miscompares++;
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || w_ready) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      $display("FAIL one_quiet: got %0d done/w_ready cycles want 0", seen);
      miscompares++;
    end
  endtask

  task automatic test_multi_chunk();
    logic ok;
    logic [3:0] exp_d [4];
    int seen;
    exp_d[0] = 4'hA; exp_d[1] = 4'h5; exp_d[2] = 4'hF; exp_d[3] = 4'h0;
    aready = 1'b1;
    begin_frame(12'd10);
    give_word(16'hA5F0, 1'b0, 6'd0, ok);
    collect(14);
    vectors++;
    if (n_ch !== 4) begin
      $display("FAIL multi_count: got %0d chunks want 4", n_ch);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ch_data[i] !== exp_d[i] || ch_len[i] !== 3'd4) begin
        $display("FAIL multi_chunk%0d: got data=%h len=%0d want data=%h len=4",
                 i, ch_data[i], ch_len[i], exp_d[i]);
        miscompares++;
      end
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (ch_cyc[i] - ch_cyc[i-1] < int'(HOLDOFF)) begin
        $display("FAIL multi_gap%0d: got %0d cycles want >= %0d",
                 i, ch_cyc[i] - ch_cyc[i-1], HOLDOFF);
        miscompares++;
      end
    end
    vectors++;
    if (w_ready !== 1'b1) begin
      $display("FAIL multi_refetch: got w_ready=%b want 1", w_ready);
      miscompares++;
    end
    give_word(16'hCBFF, 1'b1, 6'd6, ok);
    collect(10);
    vectors++;
    if (n_ch !== 2 || ch_data[0] !== 4'hC || ch_len[0] !== 3'd4 ||
        ch_data[1] !== 4'h2 || ch_len[1] !== 3'd2) begin
      $display("FAIL last_chunks: got n=%0d %h/%0d %h/%0d want n=2 c/4 2/2",
               n_ch, ch_data[0], ch_len[0], ch_data[1], ch_len[1]);
      miscompares++;
    end
    vectors++;
    if (w_ready !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL drain_state: got w_ready=%b busy=%b want 0 1", w_ready, busy);
      miscompares++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || busy) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin
      $display("FAIL drain_abort: got %0d done/busy cycles want 0", seen);
      miscompares++;
    end
  endtask

  task automatic test_underrun();
    logic ok;
    int k;
    aready = 1'b1;
    begin_frame(12'd5);
    give_word(16'h1234, 1'b1, 6'd4, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (svalid) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (ok !== 1'b1 || in_data !== 4'h1 || in_len !== 3'd4) begin
      $display("FAIL under_chunk: got seen=%b data=%h len=%0d want 1 1 4", ok, in_data, in_len);
      miscompares++;
    end
    tick(); tick();
    tvalid = 1'b1;
    tick(); tick();
    tvalid = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        k = i;
        break;
      end
    end
    vectors++;
    if (k !== int'(TIMEOUT) + 1) begin
      $display("FAIL under_timing: got done after %0d cycles want %0d", k, TIMEOUT + 1);
      miscompares++;
    end
    vectors++;
    if (err_underrun !== 1'b1 || sym_count !== 12'd2) begin
      $display("FAIL under_status: got err=%b sym=%0d want 1 2", err_underrun, sym_count);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_zero_syms();
    begin_frame(12'd0);
    vectors++;
    if (err_underrun !== 1'b0 || sym_count !== 12'd0) begin
      $display("FAIL zero_clear: got err=%b sym=%0d want 0 0", err_underrun, sym_count);
      miscompares++;
    end
    vectors++;
    if (done !== 1'b0 || w_ready !== 1'b0) begin
      $display("FAIL zero_early: got done=%b w_ready=%b want 0 0", done, w_ready);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || w_ready !== 1'b0) begin
      $display("FAIL zero_done: got done=%b busy=%b w_ready=%b want 1 0 0", done, busy, w_ready);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      $display("FAIL zero_pulse: got done=%b want 0", done);
      miscompares++;
    end
  endtask

  task automatic test_abort();
    logic ok;
    int seen;
    aready = 1'b0;
    begin_frame(12'd4);
    give_word(16'hFFFF, 1'b0, 6'd0, ok);
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    vectors++;
    if (sym_count !== 12'd1) begin
      $display("FAIL abort_precount: got %0d want 1", sym_count);
      miscompares++;
    end
    aready = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (svalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sym_count !== 12'd1) begin
      $display("FAIL abort_feed: got svalid=%b busy=%b done=%b sym=%0d want 0 0 0 1",
               svalid, busy, done, sym_count);
      miscompares++;
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (svalid || done || w_ready) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
      miscompares++;
    end
    begin_frame(12'd1);
    vectors++;
    if (sym_count !== 12'd0 || busy !== 1'b1) begin
      $display("FAIL restart: got sym=%0d busy=%b want 0 1", sym_count, busy);
      miscompares++;
    end
    give_word(16'h9000, 1'b1, 6'd4, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (svalid) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (ok !== 1'b1 || in_data !== 4'h9 || in_len !== 3'd4) begin
      $display("FAIL restart_chunk: got seen=%b data=%h len=%0d want 1 9 4", ok, in_data, in_len);
      miscompares++;
    end
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tick();
    vectors++;
    if (done !== 1'b1 || sym_count !== 12'd1) begin
      $display("FAIL restart_done: got done=%b sym=%0d want 1 1", done, sym_count);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_early_finish();
    logic ok;
    int sv, dn;
    aready = 1'b1;
    begin_frame(12'd2);
    give_word(16'hABCD, 1'b1, 6'd12, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (svalid) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (ok !== 1'b1 || in_data !== 4'hA) begin
      $display("FAIL early_first: got seen=%b data=%h want 1 a", ok, in_data);
      miscompares++;
    end
    tvalid = 1'b1;
    sv = 0;
    dn = 0;
    tick();
    if (svalid) sv++;
    tick();
    if (svalid) sv++;
    tvalid = 1'b0;
    vectors++;
    if (sym_count !== 12'd2) begin
      $display("FAIL early_count: got %0d want 2", sym_count);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (svalid) sv++;
      if (done) dn++;
    end
    vectors++;
    if (sv !== 0 || dn !== 1 || busy !== 1'b0) begin
      $display("FAIL early_stop: got svalids=%0d dones=%0d busy=%b want 0 1 0", sv, dn, busy);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    aready = 1'b1;
    begin_frame(12'd3);
    give_word(16'h5555, 1'b0, 6'd0, ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (svalid) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (ok !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL rst_setup: got svalid_seen=%b busy=%b want 1 1", ok, busy);
      miscompares++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({svalid, busy, w_ready, done, err_underrun} !== 5'b0 || {in_data, in_len} !== 7'b0) begin
      $display("FAIL rst_async: got flags=%b chunk=%h want 00000 0",
               {svalid, busy, w_ready, done, err_underrun}, {in_data, in_len});
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    vectors++;
    if (w_ready !== 1'b0 || svalid !== 1'b0 || sym_count !== 12'd0) begin
      $display("FAIL rst_idle: got w_ready=%b svalid=%b sym=%0d want 0 0 0",
               w_ready, svalid, sym_count);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_one_chunk();
    test_multi_chunk();
    test_underrun();
    test_zero_syms();
    test_abort();
    test_early_finish();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
